// File: rtl/scarv_cop_palu_mpadd_seq.sv
// Multi-precision add/sub sequencer: one word per cycle through the packed adder, rsp len+1 cycles after accept (1 on length error).
// rsp held until rsp_ready; requests only taken in IDLE. Define SCARV_COP_MPADD_SEQ_ABORT_EN to add the abort input.
module scarv_cop_palu_mpadd_seq #(
  parameter int REG_AW  = 4,
  parameter int LEN_W   = 4,
  parameter int MAX_LEN = 8
) (
  input  logic              g_clk,
  input  logic              g_reset,
`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
  input  logic              abort,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [REG_AW-1:0] req_rs1,
  input  logic [REG_AW-1:0] req_rs2,
  input  logic [REG_AW-1:0] req_rd,
  input  logic [LEN_W-1:0]  req_len,
  input  logic              req_sub,
  input  logic              req_ci,
  output logic [REG_AW-1:0] rf_raddr1,
  output logic [REG_AW-1:0] rf_raddr2,
  input  logic [31:0]       rf_rdata1,
  input  logic [31:0]       rf_rdata2,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [31:0]       add_a,
  output logic [31:0]       add_b,
  output logic [2:0]        add_pw,
  output logic              add_sub,
  output logic              add_ci,
  input  logic [31:0]       add_c,
  input  logic              add_co,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_co,
  output logic              rsp_err
);

  localparam logic [2:0]     SCARV_COP_PW_1 = 3'b001;
  localparam logic [LEN_W:0] MAX_LEN_W      = (LEN_W+1)'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [REG_AW-1:0] rs1_q, rs1_d;
  logic [REG_AW-1:0] rs2_q, rs2_d;
  logic [REG_AW-1:0] rd_q, rd_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic              sub_q, sub_d;
  logic              ci_q, ci_d;
  logic              carry_q, carry_d;
  logic              err_q, err_d;

  logic              abort_w;
  logic              len_bad;
  logic              last_word;
  logic [REG_AW-1:0] idx_a;

`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
  assign abort_w = abort;
`else
  assign abort_w = 1'b0;
`endif

  assign len_bad   = (req_len == '0) || ({1'b0, req_len} > MAX_LEN_W);
  assign last_word = (idx_q == (len_q - LEN_W'(1)));
  assign idx_a     = REG_AW'(idx_q);

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          state_d = len_bad ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (abort_w) begin
          state_d = S_IDLE;
        end else if (last_word) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // abort outranks rsp_ready: either way the response is gone
        if (abort_w || rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    len_d   = len_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    ci_d    = ci_q;
    carry_d = carry_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          rs1_d   = req_rs1;
          rs2_d   = req_rs2;
          rd_d    = req_rd;
          len_d   = req_len;
          sub_d   = req_sub;
          ci_d    = req_ci;
          idx_d   = '0;
          carry_d = 1'b0;
          err_d   = len_bad;
        end
      end
      S_RUN: begin
        if (!abort_w) begin
          carry_d = add_co;
          idx_d   = idx_q + LEN_W'(1);
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge g_clk) begin
    if (g_reset) begin
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      sub_q   <= 1'b0;
      ci_q    <= 1'b0;
      carry_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      ci_q    <= ci_d;
      carry_q <= carry_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    req_ready = 1'b0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    rf_wen    = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    add_a     = '0;
    add_b     = '0;
    add_pw    = SCARV_COP_PW_1;
    add_sub   = 1'b0;
    add_ci    = 1'b0;
    rsp_valid = 1'b0;
    rsp_co    = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
      end
      S_RUN: begin
        // Read data is combinational, so word i+1 sees the word-i write
        rf_raddr1 = rs1_q + idx_a;
        rf_raddr2 = rs2_q + idx_a;
        rf_waddr  = rd_q + idx_a;
        add_a     = rf_rdata1;
        add_b     = rf_rdata2;
        add_sub   = sub_q;
        add_ci    = (idx_q == '0) ? ci_q : carry_q;
        rf_wdata  = add_c;
        rf_wen    = !abort_w && !g_reset;
      end
      S_DONE: begin
        rsp_valid = 1'b1;
        rsp_co    = carry_q;
        rsp_err   = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_scarv_cop_palu_mpadd_seq.sv
// Bench for scarv_cop_palu_mpadd_seq: register file and adder environment, word-level reference model.
module tb_scarv_cop_palu_mpadd_seq;

  logic        g_clk = 1'b0;
  logic        g_reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_rs1, req_rs2, req_rd, req_len;
  logic        req_sub, req_ci;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata;
  logic        rf_wen;
  logic [31:0] add_a, add_b, add_c;
  logic [2:0]  add_pw;
  logic        add_sub, add_ci, add_co;
  logic        rsp_valid, rsp_ready, rsp_co, rsp_err;
`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
  logic        abort;
`endif

  scarv_cop_palu_mpadd_seq dut (
    .g_clk(g_clk), .g_reset(g_reset),
`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
    .abort(abort),
`endif
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_len(req_len),
    .req_sub(req_sub), .req_ci(req_ci),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .add_a(add_a), .add_b(add_b), .add_pw(add_pw), .add_sub(add_sub), .add_ci(add_ci),
    .add_c(add_c), .add_co(add_co),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_co(rsp_co), .rsp_err(rsp_err)
  );

  initial forever #5 g_clk = ~g_clk;

  // Environment: GPR file with combinational read, and a 32-bit adder
  logic [31:0] mem [16];
  logic        pl_en;
  logic [3:0]  pl_addr;
  logic [31:0] pl_data;
  logic [32:0] add_sum;

  always @(posedge g_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (rf_wen) mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata1 = mem[rf_raddr1];
  assign rf_rdata2 = mem[rf_raddr2];
  assign add_sum   = {1'b0, add_a} + {1'b0, (add_sub ? ~add_b : add_b)} + {32'd0, add_ci};
  assign add_c     = add_sum[31:0];
  assign add_co    = add_sum[32];

  // Reference state and per-cycle expectations (phase: 0 idle, 1 run, 2 done, 3 unchecked, 4 aborted word)
  logic [31:0] ref_mem [16];
  int          exp_phase;
  logic [3:0]  exp_ra1, exp_ra2, exp_wa;
  logic [31:0] exp_a, exp_b, exp_wd;
  logic        exp_sub, exp_ci, exp_co, exp_err;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge g_clk) begin
    if (exp_phase != 3) begin
      chk("add_pw", 32'(add_pw), 32'd1);
      case (exp_phase)
        0: begin
          chk("idle_req_ready", 32'(req_ready), 32'd1);
          chk("idle_rf_wen", 32'(rf_wen), 32'd0);
          chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
          chk("idle_rsp_co", 32'(rsp_co), 32'd0);
          chk("idle_rsp_err", 32'(rsp_err), 32'd0);
          chk("idle_add_ci", 32'(add_ci), 32'd0);
          chk("idle_rf_waddr", 32'(rf_waddr), 32'd0);
        end
        1: begin
          chk("run_req_ready", 32'(req_ready), 32'd0);
          chk("run_rf_wen", 32'(rf_wen), 32'd1);
          chk("run_raddr1", 32'(rf_raddr1), 32'(exp_ra1));
          chk("run_raddr2", 32'(rf_raddr2), 32'(exp_ra2));
          chk("run_waddr", 32'(rf_waddr), 32'(exp_wa));
          chk("run_add_a", add_a, exp_a);
          chk("run_add_b", add_b, exp_b);
          chk("run_add_sub", 32'(add_sub), 32'(exp_sub));
          chk("run_add_ci", 32'(add_ci), 32'(exp_ci));
          chk("run_wdata", rf_wdata, exp_wd);
          chk("run_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        2: begin
          chk("done_req_ready", 32'(req_ready), 32'd0);
          chk("done_rf_wen", 32'(rf_wen), 32'd0);
          chk("done_rsp_valid", 32'(rsp_valid), 32'd1);
          chk("done_rsp_co", 32'(rsp_co), 32'(exp_co));
          chk("done_rsp_err", 32'(rsp_err), 32'(exp_err));
        end
        4: begin
          chk("abort_rf_wen", 32'(rf_wen), 32'd0);
          chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        default: begin
        end
      endcase
    end
  end

  task automatic step();
    @(posedge g_clk);
    #1;
  endtask

  task automatic set_reg(input logic [3:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    ref_mem[a] = d;
    step();
    pl_en = 1'b0;
  endtask

  // One full operation; cut_at >= 0 interrupts at that word by reset (or abort when cut_abort)
  task automatic run_op(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                        input logic [3:0] len, input logic sub, input logic ci, input int hold,
                        input int cut_at, input bit cut_abort, output logic model_co);
    logic       carry;
    bit         bad;
    logic [32:0] s;
    logic [3:0] ia, ib, iw;
    bad = (len == 4'd0) || (len > 4'd8);
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd;
    req_len = len; req_sub = sub; req_ci = ci;
    step();
    req_valid = 1'(($urandom % 2)); req_rs1 = 4'($urandom); req_len = 4'($urandom);
    carry = ci;
    model_co = 1'b0;
    if (!bad) begin
      for (int i = 0; i < int'(len); i++) begin
        ia = rs1 + 4'(i); ib = rs2 + 4'(i); iw = rd + 4'(i);
        if (i == cut_at) begin
          if (cut_abort) begin
`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
            abort = 1'b1; exp_phase = 4;
            step();
            abort = 1'b0;
`endif
          end else begin
            g_reset = 1'b1; exp_phase = 3;
            step();
            g_reset = 1'b0;
            ref_mem[iw] = mem[iw];
          end
          exp_phase = 0; req_valid = 1'b0; rsp_ready = 1'b0;
          for (int r = 0; r < 16; r++) chk("cut_reg", mem[r], ref_mem[r]);
          return;
        end
        exp_phase = 1; exp_ra1 = ia; exp_ra2 = ib; exp_wa = iw;
        exp_a = ref_mem[ia]; exp_b = ref_mem[ib]; exp_sub = sub; exp_ci = carry;
        s = {1'b0, exp_a} + {1'b0, (sub ? ~exp_b : exp_b)} + 33'(carry);
        exp_wd = s[31:0];
        ref_mem[iw] = s[31:0];
        carry = s[32];
        rsp_ready = 1'(($urandom % 2)); req_valid = 1'(($urandom % 2));
        step();
      end
      model_co = carry;
    end
    exp_phase = 2; exp_co = model_co; exp_err = bad; rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      req_valid = 1'(($urandom % 2));
      step();
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0; req_valid = 1'b0; exp_phase = 0;
    for (int r = 0; r < 16; r++) chk("rf_reg", mem[r], ref_mem[r]);
  endtask

  initial begin
    logic co;
    g_reset = 1'b1; req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rd = '0; req_len = '0;
    req_sub = 1'b0; req_ci = 1'b0; rsp_ready = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    exp_phase = 3;
    step();
    exp_phase = 0;
    step();
    g_reset = 1'b0;
    for (int r = 0; r < 16; r++) set_reg(4'(r), $urandom);

    // 1: single word wraps to zero with carry out
    set_reg(4'd0, 32'hFFFFFFFF); set_reg(4'd1, 32'd1);
    run_op(4'd0, 4'd1, 4'd2, 4'd1, 1'b0, 1'b0, 0, -1, 1'b0, co);
    chk("t1_model_rd", ref_mem[2], 32'd0);
    chk("t1_dut_rd", mem[2], 32'd0);
    chk("t1_co", 32'(co), 32'd1);

    // 2: four words, carry ripples through, response held 5 cycles
    for (int r = 0; r < 4; r++) set_reg(4'(r), 32'hFFFFFFFF);
    set_reg(4'd4, 32'd1); set_reg(4'd5, 32'd0); set_reg(4'd6, 32'd0); set_reg(4'd7, 32'd0);
    run_op(4'd0, 4'd4, 4'd8, 4'd4, 1'b0, 1'b0, 5, -1, 1'b0, co);
    for (int r = 8; r < 12; r++) chk("t2_dut_rd", mem[r], 32'd0);
    chk("t2_co", 32'(co), 32'd1);

    // 3: two-word subtract, with and without final borrow
    set_reg(4'd0, 32'd0); set_reg(4'd1, 32'd1); set_reg(4'd2, 32'd1); set_reg(4'd3, 32'd0);
    run_op(4'd0, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1, 1, -1, 1'b0, co);
    chk("t3a_rd0", mem[4], 32'hFFFFFFFF);
    chk("t3a_rd1", mem[5], 32'd0);
    chk("t3a_co", 32'(co), 32'd1);
    set_reg(4'd1, 32'd0);
    run_op(4'd0, 4'd2, 4'd4, 4'd2, 1'b1, 1'b1, 0, -1, 1'b0, co);
    chk("t3b_rd1", mem[5], 32'hFFFFFFFF);
    chk("t3b_co", 32'(co), 32'd0);

    // 4: illegal lengths
    run_op(4'd0, 4'd1, 4'd2, 4'd0, 1'b0, 1'b1, 2, -1, 1'b0, co);
    run_op(4'd0, 4'd1, 4'd2, 4'd9, 1'b0, 1'b1, 0, -1, 1'b0, co);

    // 5: address wrap, word 1 reads the word-0 result in r15
    set_reg(4'd14, 32'd5); set_reg(4'd15, 32'd7); set_reg(4'd0, 32'd9);
    set_reg(4'd3, 32'd1); set_reg(4'd4, 32'd2); set_reg(4'd5, 32'd3);
    run_op(4'd14, 4'd3, 4'd15, 4'd3, 1'b0, 1'b0, 0, -1, 1'b0, co);
    chk("t5_r15", mem[15], 32'd6);
    chk("t5_r0", mem[0], 32'd8);
    chk("t5_r1", mem[1], 32'd11);

    // Random operations, including error lengths and overlapping ranges
    for (int n = 0; n < 60; n++) begin
      run_op(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom_range(0, 10)),
             1'(($urandom % 2)), 1'(($urandom % 2)), int'($urandom_range(0, 3)), -1, 1'b0, co);
    end

    // Reset mid-operation, then a normal operation
    run_op(4'd1, 4'd2, 4'd3, 4'd6, 1'b0, 1'b1, 0, 2, 1'b0, co);
    run_op(4'd5, 4'd9, 4'd12, 4'd8, 1'b1, 1'b1, 1, -1, 1'b0, co);

`ifdef SCARV_COP_MPADD_SEQ_ABORT_EN
    run_op(4'd0, 4'd4, 4'd8, 4'd5, 1'b0, 1'b0, 0, 2, 1'b1, co);
    run_op(4'd2, 4'd3, 4'd4, 4'd3, 1'b0, 1'b0, 0, -1, 1'b0, co);
`endif

    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
